// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet types, flit field positions, node addresses
// and the receive FIFO entry layout.
package noc_pkg;

  typedef enum logic [1:0] {
    PktFilter = 2'b00,
    PktIfmap  = 2'b01,
    PktPsum   = 2'b10,
    PktBurst  = 2'b11
  } pkt_type_e;

  localparam int unsigned DEST_MSB    = 31;
  localparam int unsigned DEST_LSB    = 29;
  localparam int unsigned SRC_MSB     = 28;
  localparam int unsigned SRC_LSB     = 26;
  localparam int unsigned TYPE_MSB    = 25;
  localparam int unsigned TYPE_LSB    = 24;
  localparam int unsigned PAYLOAD_MSB = 23;
  localparam int unsigned LEN_MSB     = 3;

  localparam logic [2:0] ADDR_PE1 = 3'b001;
  localparam logic [2:0] ADDR_PE2 = 3'b010;
  localparam logic [2:0] ADDR_PE3 = 3'b011;
  localparam logic [2:0] ADDR_MEM = 3'b100;

  localparam int unsigned ENTRY_W = 30;

  typedef struct packed {
    pkt_type_e   typ;
    logic [2:0]  src;
    logic [23:0] payload;
    logic        last;
  } rx_entry_t;

endpackage

// File: rtl/noc_rx_fifo.sv
// Register-based first-word-fall-through FIFO; the head entry is read directly
// from storage so it stays stable while it waits to be popped.
module noc_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push && (!full || do_pop);

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/noc_packet_receiver.sv
// NoC leaf receiver: decodes headers addressed to this node, unpacks bursts,
// drops misrouted packets and queues entries for the processing element.
module noc_packet_receiver
  import noc_pkg::*;
#(
  parameter logic [2:0]  ADDRESS = 3'b001,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  out_type,
  output logic [2:0]  out_src,
  output logic [23:0] out_payload,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  misroute_cnt
);

  typedef enum logic [1:0] {StIdle, StBurst, StDrop} state_e;

  state_e     state_q, state_d;
  logic [3:0] len_q, len_d;
  logic [2:0] src_q, src_d;
  logic [7:0] mis_q, mis_d;

  logic       fifo_full, fifo_empty, pop, push, accept;
  rx_entry_t  push_entry, head_entry;

  logic [2:0] hdr_dest, hdr_src;
  logic [3:0] hdr_len;
  pkt_type_e  hdr_type;

  assign hdr_dest = in_data[DEST_MSB:DEST_LSB];
  assign hdr_src  = in_data[SRC_MSB:SRC_LSB];
  assign hdr_type = pkt_type_e'(in_data[TYPE_MSB:TYPE_LSB]);
  assign hdr_len  = in_data[LEN_MSB:0];

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign in_ready  = !reset && ((state_q == StDrop) || !fifo_full || pop);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    src_d      = src_q;
    mis_d      = mis_q;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_dest == ADDRESS) begin
            if (hdr_type != PktBurst) begin
              push       = 1'b1;
              push_entry = '{typ: hdr_type, src: hdr_src,
                             payload: in_data[PAYLOAD_MSB:0], last: 1'b1};
            end else if (hdr_len != 4'd0) begin
              len_d   = hdr_len;
              src_d   = hdr_src;
              state_d = StBurst;
            end
          end else begin
            if (mis_q != 8'hFF) mis_d = mis_q + 8'd1;
            if (hdr_type == PktBurst && hdr_len != 4'd0) begin
              len_d   = hdr_len;
              state_d = StDrop;
            end
          end
        end
      end
      StBurst: begin
        if (accept) begin
          push       = 1'b1;
          push_entry = '{typ: PktBurst, src: src_q,
                         payload: in_data[PAYLOAD_MSB:0], last: (len_q == 4'd1)};
          len_d      = len_q - 4'd1;
          if (len_q == 4'd1) state_d = StIdle;
        end
      end
      StDrop: begin
        if (accept) begin
          len_d = len_q - 4'd1;
          if (len_q == 4'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      src_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      src_q   <= src_d;
      mis_q   <= mis_d;
    end
  end

  noc_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_type     = head_entry.typ;
  assign out_src      = head_entry.src;
  assign out_payload  = head_entry.payload;
  assign out_last     = head_entry.last;
  assign misroute_cnt = mis_q;

endmodule

// File: tb/tb_noc_packet_receiver.sv
// Randomized bench: packets are expanded into a flit stream plus the list of
// entries the PE should receive, and the DUT is compared against that list.
module tb_noc_packet_receiver;
  localparam logic [2:0]  Addr  = 3'b001;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  out_type;
  logic [2:0]  out_src;
  logic [23:0] out_payload;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  misroute_cnt;

  noc_packet_receiver #(.ADDRESS(Addr), .DEPTH(Depth)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_type(out_type), .out_src(out_src), .out_payload(out_payload), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .misroute_cnt(misroute_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          push;  // flit yields one PE entry
    bit          drop;  // flit is swallowed after a misrouted burst header
  } flit_t;

  flit_t       flits[$];
  logic [29:0] exp_q[$];
  int          occ;
  int          exp_mis;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void add_single(input logic [2:0] dest, input logic [2:0] src,
                                     input logic [1:0] typ, input logic [23:0] pl);
    flit_t f;
    f.data = {dest, src, typ, pl};
    f.push = (dest == Addr);
    f.drop = 1'b0;
    flits.push_back(f);
    if (dest == Addr) exp_q.push_back({typ, src, pl, 1'b1});
    else if (exp_mis < 255) exp_mis++;
  endfunction

  function automatic void add_burst(input logic [2:0] dest, input logic [2:0] src,
                                    input int len);
    flit_t      f;
    logic [3:0] l = 4'(len);
    logic [19:0] junk = 20'($urandom);
    f.data = {dest, src, 2'b11, junk, l};
    f.push = 1'b0;
    f.drop = 1'b0;
    flits.push_back(f);
    if (dest != Addr && exp_mis < 255) exp_mis++;
    for (int i = 0; i < len; i++) begin
      f.data = $urandom;
      f.push = (dest == Addr);
      f.drop = (dest != Addr);
      flits.push_back(f);
      if (dest == Addr) exp_q.push_back({2'b11, src, f.data[23:0], i == len - 1});
    end
  endfunction

  // Drive the pending flit stream with random valid/ready; bounded by budget cycles.
  task automatic run(input int vpct, input int rpct, input int budget);
    int   cyc = 0;
    logic exp_rdy;
    logic [29:0] e;
    while ((flits.size() > 0 || occ > 0) && cyc < budget) begin
      @(negedge clk);
      in_valid  = (flits.size() > 0) && (($urandom % 100) < vpct);
      in_data   = in_valid ? flits[0].data : $urandom;
      out_ready = (($urandom % 100) < rpct);
      #1;
      check_eq("out_valid", out_valid, occ > 0);
      exp_rdy = (flits.size() > 0 && flits[0].drop) || (occ < Depth) || (occ > 0 && out_ready);
      check_eq("in_ready", in_ready, exp_rdy);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_entry", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("entry", {out_type, out_src, out_payload, out_last}, e);
        end
        occ--;
      end
      if (in_valid && in_ready) begin
        if (flits[0].push) occ++;
        void'(flits.pop_front());
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
  endtask

  task automatic check_done(input string tag);
    check_eq({tag, "_flits_left"}, flits.size(), 0);
    check_eq({tag, "_entries_left"}, exp_q.size(), 0);
    check_eq({tag, "_misroute_cnt"}, misroute_cnt, exp_mis);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check_eq("in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("reset_outputs", {out_valid, out_type, out_src, out_payload, out_last}, 0);
    check_eq("reset_misroute", misroute_cnt, 0);
    check_eq("reset_in_ready", in_ready, 1);
    flits.delete();
    exp_q.delete();
    occ     = 0;
    exp_mis = 0;
  endtask

  task automatic send_raw(input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 20) check_eq("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single flit addressed to this node.
    add_single(Addr, 3'b001, 2'b00, 24'd5);
    run(100, 100, 20);
    check_done("single");

    // Burst of three.
    add_burst(Addr, 3'b010, 3);
    run(100, 100, 30);
    check_done("burst");

    // Misrouted burst followed by a good single.
    add_burst(3'b010, 3'b011, 2);
    add_single(Addr, 3'b100, 2'b01, 24'h123456);
    run(100, 100, 30);
    check_done("misroute");

    // Backpressure: five singles with the PE stalled.
    for (int i = 0; i < 5; i++) add_single(Addr, 3'b010, 2'b10, 24'(i + 1));
    run(100, 0, 12);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_pending", flits.size(), 1);
    run(100, 100, 40);
    check_done("backpressure");

    // Random mix of packets.
    for (int p = 0; p < 60; p++) begin
      logic [2:0] d = ($urandom % 3 == 0) ? 3'($urandom) : Addr;
      int         k = $urandom % 4;
      if (k == 3) add_burst(d, 3'($urandom), $urandom % 16);
      else add_single(d, 3'($urandom), 2'(k), 24'($urandom));
    end
    run(70, 60, 6000);
    check_done("random");

    // Reset in the middle of a burst.
    do_reset();
    send_raw({Addr, 3'b011, 2'b11, 20'h0, 4'd3});
    send_raw(32'h0000_000A);
    @(negedge clk);
    check_eq("midburst_entry", out_valid, 1);
    do_reset();
    add_single(Addr, 3'b010, 2'b10, 24'h00ABCD);
    run(100, 100, 20);
    check_done("after_reset");

    // Saturation of the misroute counter.
    for (int i = 0; i < 300; i++) add_single(3'b100, 3'($urandom), 2'($urandom % 3), 24'($urandom));
    run(100, 100, 400);
    check_done("saturation");
    check_eq("saturated_value", misroute_cnt, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
